// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported unified Memory between fetch (I) and
// data (D) requesters. Data has fixed priority; the winner's address, write data
// and write-enable are registered toward Memory, and the read data is returned
// one cycle after the access.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN. When defined, a run counter
// forces an I grant after MAX_DATA_RUN back-to-back D grants while I waits.
module mem_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IGnt,
  output logic        IValid,
  output logic [31:0] IData,
  input  logic        DReq,
  input  logic        DWE,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic        DGnt,
  output logic        DValid,
  output logic [31:0] DData,
  output logic [31:0] MemA,
  output logic [31:0] MemWD,
  output logic        MemWE,
  output logic        MemRead,
  input  logic [31:0] MemRD
);

  // Owner of the access currently presented to Memory
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_I    = 2'd1,
    PEND_DRD  = 2'd2,
    PEND_DWR  = 2'd3
  } pend_e;

  // Everything registered toward Memory in one transfer
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        rd;
    pend_e       owner;
  } acc_t;

  logic  force_i;
  logic  i_xfer, d_xfer;
  pend_e pend;
  acc_t  acc_nxt;

  // Request/grant handshake; at most one grant per cycle
  always_comb begin
    IGnt = 1'b0;
    DGnt = 1'b0;
    if (!RESET) begin
      DGnt = DReq && !force_i;
      IGnt = IReq && (!DReq || force_i);
    end
  end

  assign i_xfer = IReq && IGnt;
  assign d_xfer = DReq && DGnt;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);
  logic [3:0] run;

  // Counts consecutive D transfers while I is waiting; saturates at RUN_MAX
  always_ff @(posedge CLK) begin
    if (RESET)                run <= 4'd0;
    else if (d_xfer && IReq) begin
      if (run != RUN_MAX)     run <= run + 4'd1;
    end
    else if (i_xfer || !IReq) run <= 4'd0;
  end

  assign force_i = (run == RUN_MAX);
`else
  // Strict D priority: fetch may starve under continuous data traffic
  assign force_i = 1'b0;
`endif

  // Next access toward Memory; address/write data hold when nothing transfers
  always_comb begin
    acc_nxt.addr  = MemA;
    acc_nxt.wdata = MemWD;
    acc_nxt.we    = 1'b0;
    acc_nxt.rd    = 1'b0;
    acc_nxt.owner = PEND_NONE;
    if (d_xfer) begin
      acc_nxt.addr  = DAddr;
      acc_nxt.wdata = DWData;
      acc_nxt.we    = DWE;
      acc_nxt.rd    = !DWE;
      acc_nxt.owner = DWE ? PEND_DWR : PEND_DRD;
    end else if (i_xfer) begin
      acc_nxt.addr  = IAddr;
      acc_nxt.rd    = 1'b1;
      acc_nxt.owner = PEND_I;
    end
  end

  // Memory-side registers and the in-flight owner
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MemA    <= 32'd0;
      MemWD   <= 32'd0;
      MemWE   <= 1'b0;
      MemRead <= 1'b0;
      pend    <= PEND_NONE;
    end else begin
      MemA    <= acc_nxt.addr;
      MemWD   <= acc_nxt.wdata;
      MemWE   <= acc_nxt.we;
      MemRead <= acc_nxt.rd;
      pend    <= acc_nxt.owner;
    end
  end

  // Response: Memory.RD settles at the negedge, captured here one edge later.
  // Reset drops the response of an access that already hit Memory.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      IValid <= 1'b0;
      DValid <= 1'b0;
      IData  <= 32'd0;
      DData  <= 32'd0;
    end else begin
      IValid <= (pend == PEND_I);
      DValid <= (pend == PEND_DRD) || (pend == PEND_DWR);
      if (pend == PEND_I)   IData <= MemRD;
      if (pend == PEND_DRD) DData <= MemRD;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters against a transaction-level scoreboard.
// A behavioural Memory (write then read on negedge) sits on the Mem* port; the
// scoreboard keeps its own word array updated at grant time and predicts
// grants, Memory-side registers and responses.
module tb_mem_arbiter;
  localparam int MAX_RUN = 4;
  localparam int NCYC    = 3000;
  localparam int SAT_END = 600;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IReq = 1'b0, DReq = 1'b0, DWE = 1'b0;
  logic [31:0] IAddr = '0, DAddr = '0, DWData = '0;
  logic        IGnt, DGnt, IValid, DValid, MemWE, MemRead;
  logic [31:0] IData, DData, MemA, MemWD;
  logic [31:0] MemRD = '0;

  mem_arbiter #(.MAX_DATA_RUN(MAX_RUN)) dut (
    .CLK(CLK), .RESET(RESET),
    .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IValid(IValid), .IData(IData),
    .DReq(DReq), .DWE(DWE), .DAddr(DAddr), .DWData(DWData), .DGnt(DGnt),
    .DValid(DValid), .DData(DData),
    .MemA(MemA), .MemWD(MemWD), .MemWE(MemWE), .MemRead(MemRead), .MemRD(MemRD)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0, n_err = 0, cyc = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Behavioural single-port Memory
  logic [31:0] env_mem [int unsigned];
  always @(negedge CLK) begin
    if (MemWE === 1'b1) env_mem[MemA[31:2]] = MemWD;
    if ($isunknown(MemA))                MemRD = 32'd0;
    else if (env_mem.exists(MemA[31:2])) MemRD = env_mem[MemA[31:2]];
    else                                 MemRD = init_word({MemA[31:2], 2'b00});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Scoreboard state
  logic [31:0] ref_mem [int unsigned];
  int          m_pend = 0;          // 0 none, 1 I, 2 D read, 3 D write
  logic [31:0] m_pdata = '0;
  logic [31:0] m_mema = '0, m_memwd = '0, m_idata = '0, m_ddata = '0;
  logic        m_memwe = 0, m_memrd = 0, m_ival = 0, m_dval = 0;
  int          m_run = 0;
  int          x_kind = 0;
  logic [31:0] x_addr = '0, x_wd = '0, x_data = '0;
  logic        x_rst = 1'b1;
  logic        i_hold = 0, d_hold = 0, ig_prev = 0, dg_prev = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return init_word({a[31:2], 2'b00});
  endfunction

  initial begin
    int  prob;
    logic eg_i, eg_d, frc, guard;
`ifdef MEM_ARB_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    IReq = 1'b1; DReq = 1'b1;
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge CLK); #1;
      // Scoreboard view of the edge that just happened
      if (x_rst) begin
        m_pend = 0; m_mema = '0; m_memwd = '0; m_memwe = 0; m_memrd = 0;
        m_ival = 0; m_dval = 0; m_idata = '0; m_ddata = '0;
      end else begin
        m_ival = (m_pend == 1);
        m_dval = (m_pend >= 2);
        if (m_pend == 1) m_idata = m_pdata;
        if (m_pend == 2) m_ddata = m_pdata;
        m_pend  = x_kind;
        m_pdata = x_data;
        if (x_kind != 0) m_mema = x_addr;
        if (x_kind >= 2) m_memwd = x_wd;
        m_memwe = (x_kind == 3);
        m_memrd = (x_kind == 1) || (x_kind == 2);
      end
      chk("IValid", IValid, m_ival);
      chk("DValid", DValid, m_dval);
      chk("IData", IData, m_idata);
      chk("DData", DData, m_ddata);
      chk("MemA", MemA, m_mema);
      chk("MemWD", MemWD, m_memwd);
      chk("MemWE", MemWE, m_memwe);
      chk("MemRead", MemRead, m_memrd);

      // New stimulus for this cycle
      if (cyc < 1) RESET = 1'b1;
      else if (cyc >= SAT_END && x_kind == 2 && $urandom_range(0, 3) == 0) RESET = 1'b1;
      else if (cyc >= SAT_END && $urandom_range(0, 59) == 0) RESET = 1'b1;
      else RESET = 1'b0;
      prob = (cyc < SAT_END) ? 100 : 50;
      if (ig_prev) i_hold = 0;
      if (dg_prev) d_hold = 0;
      if (cyc == 0) begin
        i_hold = 1; d_hold = 1;
        IAddr = 32'h0040_0000; DAddr = 32'h7FFF_FFFC; DWE = 0; DWData = '0;
      end
      if (!i_hold && $urandom_range(0, 99) < prob) begin
        i_hold = 1;
        IAddr = ($urandom_range(0, 1) ? 32'h0040_0000 : 32'h7FFF_FFC0)
                + 32'($urandom_range(0, 15)) * 4;
      end
      if (!d_hold && $urandom_range(0, 99) < prob) begin
        d_hold = 1;
        DAddr  = 32'h7FFF_FFC0 + 32'($urandom_range(0, 15)) * 4;
        DWE    = $urandom_range(0, 1);
        DWData = $urandom;
      end
      IReq = i_hold; DReq = d_hold;
      #1;

      // Expected grants from priority rule plus starvation guard
      frc  = guard && (m_run == MAX_RUN);
      eg_d = !RESET && DReq && !frc;
      eg_i = !RESET && IReq && (!DReq || frc);
      chk("DGnt", DGnt, eg_d);
      chk("IGnt", IGnt, eg_i);

      x_kind = 0; x_addr = '0; x_wd = '0; x_data = '0;
      if (eg_d) begin
        x_kind = DWE ? 3 : 2; x_addr = DAddr; x_wd = DWData;
        if (DWE) ref_mem[DAddr[31:2]] = DWData;
        else     x_data = ref_rd(DAddr);
      end else if (eg_i) begin
        x_kind = 1; x_addr = IAddr; x_data = ref_rd(IAddr);
      end
      if (RESET)                 m_run = 0;
      else if (eg_d && IReq)     m_run = (m_run < MAX_RUN) ? m_run + 1 : MAX_RUN;
      else if (eg_i || !IReq)    m_run = 0;
      x_rst   = RESET;
      ig_prev = eg_i;
      dg_prev = eg_d;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported unified `Memory` between the fetch stage (instruction requester, I) and the memory stage (data requester, D). Accepts one request per cycle through a combinational request/grant handshake, registers the winning address, write data and write-enable toward `Memory`, and returns read data one cycle after the access. Data has fixed priority over fetch. An optional starvation guard guarantees fetch progress.

## Interface
Parameters:
- `MAX_DATA_RUN`, 4: consecutive D grants allowed while I is waiting (guard only); legal range 1..15.

Ports:
- `CLK` in 1: single clock; all state updates on posedge.
- `RESET` in 1: synchronous, active-high reset.
- `IReq` in 1: fetch request; held with `IAddr` until granted.
- `IAddr` in 32: fetch byte address.
- `IGnt` out 1: combinational; transfer occurs on posedge when `IReq && IGnt`.
- `IValid` out 1: one-cycle pulse; `IData` valid.
- `IData` out 32: fetched word (registered).
- `DReq` in 1: data request; held with `DAddr/DWE/DWData` until granted.
- `DWE` in 1: 1 = write, 0 = read.
- `DAddr` in 32: data byte address.
- `DWData` in 32: store data.
- `DGnt` out 1: combinational grant for D.
- `DValid` out 1: one-cycle pulse; read data or write acknowledge.
- `DData` out 32: loaded word (registered).
- `MemA` out 32: registered address to `Memory.A`.
- `MemWD` out 32: registered write data to `Memory.WD`.
- `MemWE` out 1: registered write-enable to `Memory.WE`.
- `MemRead` out 1: registered; high during a read access (drives `MemToRegM`/`RegWriteM`).
- `MemRD` in 32: `Memory.RD`, updated by `Memory` on negedge.

## Operation
- Grant logic (combinational): `RESET` → `IGnt=DGnt=0`. Otherwise, `DGnt = DReq && !force_i`; `IGnt = IReq && (!DReq || force_i)`. At most one grant per cycle.
- The arbiter is always ready. There are no back-pressure states beyond losing arbitration.
- Transfer at posedge (Req && Gnt):
  - Latch `MemA` ← address.
  - Latch `MemWE` ← (D && `DWE`), `MemWD` ← `DWData` (D) or unchanged (I), `MemRead` ← !`MemWE`.
  - Record the pending owner (I/D/write) in a 2-bit in-flight register.
- No transfer: `MemWE=0`, `MemRead=0`, pending=NONE. `MemA`/`MemWD` hold their previous values.
- Response posedge (one after transfer):
  - Pending I: `IData` ← `MemRD`, `IValid`=1.
  - Pending D read: `DData` ← `MemRD`, `DValid`=1.
  - Pending D write: `DValid`=1, `DData` unchanged.
  - Otherwise both Valids are 0.
- A response and a new transfer occur on the same edge, giving full throughput of 1 access/cycle.
- Starvation counter `run` is 4 bits:
  - D transfer while `IReq`=1: `run`+1, saturating at `MAX_DATA_RUN`.
  - I transfer, or `IReq`=0: `run`=0.
  - `force_i = (run == MAX_DATA_RUN)`.

## Timing
- Reset values: `IGnt=DGnt=0`, `IValid=DValid=0`, `IData=DData=0`, `MemA=MemWD=0`, `MemWE=0`, `MemRead=0`, pending=NONE, `run=0`.
- Latency: handshake in cycle k; `Memory` access at negedge of cycle k+1; Valid and data in cycle k+2.
- A write takes effect at the negedge of cycle k+1. `MemWE` is high for exactly that one cycle.
- A read in the same cycle as a write to the same address is impossible (single port). A read granted the cycle after a write returns the new value.
- Simultaneous `IReq` and `DReq`: D wins unless `force_i`. I is granted on the first cycle `DReq`=0 or `force_i`=1.
- Reset mid-operation:
  - An access already registered completes at `Memory` (the negedge precedes the reset edge).
  - Its Valid is suppressed, pending is cleared and `run` is cleared.
  - Requesters re-issue after `RESET` drops.
- `RESET` deasserted: grants are evaluated in the same cycle.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: the starvation counter and `force_i` are compiled in, as described above.
- `MEM_ARB_STARVE_GUARD_EN` undefined: the counter is removed and `force_i` is tied to 0. Strict D priority applies, and I can starve indefinitely under continuous `DReq`. `MAX_DATA_RUN` is ignored.

## Test plan
- Reset: `RESET`=1 for 2 cycles with `IReq`=`DReq`=1 → `IGnt`=`DGnt`=0, Valids 0, `MemWE`=0, `MemA`=0, and no `Memory` write.
- Lone fetch, `IAddr`=0x0040_0000, cycle k → `IGnt`=1 in k; `MemA`=0x0040_0000 and `MemRead`=1 in k+1; `IValid`=1 with `IData`=word at that address in k+2.
- Contention, D read 0x7FFF_FFFC and I fetch both in cycle k → `DGnt`=1 and `IGnt`=0 in k; `IGnt`=1 in k+1; `DValid` in k+2; `IValid` in k+3.
- Store 0xDEAD_BEEF to 0x7FFF_FFF8, then load the same address back-to-back → `MemWE` is high exactly one cycle; `DValid` with `DData` unchanged; the load returns 0xDEAD_BEEF.
- Continuous `IReq`+`DReq`, `MAX_DATA_RUN`=4, guard defined → grant pattern D,D,D,D,I repeating. Guard undefined → D on every cycle, `IValid` never asserted.
- `RESET` pulsed in the cycle after a D read transfer → no `DValid`; `run`=0; requests resume normally on the next cycle.
